// File: rtl/turf_udp_tx_arbiter.sv
// Round-robin arbiter that merges NUM_PORTS UDP transmit streams (header + payload)
// onto one shared output; a grant is held from header acceptance until payload tlast.
module turf_udp_tx_arbiter #(
    parameter int    NUM_PORTS = 4,
    parameter string DEBUG     = "TRUE"
) (
    input  logic                      aclk,
    input  logic                      aresetn,

    input  logic [64*NUM_PORTS-1:0]   s_udphdr_tdata,
    input  logic [NUM_PORTS-1:0]      s_udphdr_tvalid,
    output logic [NUM_PORTS-1:0]      s_udphdr_tready,

    input  logic [64*NUM_PORTS-1:0]   s_udpdata_tdata,
    input  logic [8*NUM_PORTS-1:0]    s_udpdata_tkeep,
    input  logic [NUM_PORTS-1:0]      s_udpdata_tlast,
    input  logic [NUM_PORTS-1:0]      s_udpdata_tvalid,
    output logic [NUM_PORTS-1:0]      s_udpdata_tready,

    output logic [63:0]               m_udphdr_tdata,
    output logic                      m_udphdr_tvalid,
    input  logic                      m_udphdr_tready,

    output logic [63:0]               m_udpdata_tdata,
    output logic [7:0]                m_udpdata_tkeep,
    output logic                      m_udpdata_tlast,
    output logic                      m_udpdata_tvalid,
    input  logic                      m_udpdata_tready,

    output logic [NUM_PORTS-1:0]      grant_o,
    output logic                      busy_o,
    output logic [1:0]                dbg_state
);

    // Handshakes: a beat moves on a channel in any cycle where tvalid && tready are both
    // high at the rising edge of aclk; tvalid never waits on tready, ready may depend on valid.

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [NUM_PORTS-1:0] grant, grant_nxt;
    logic [IDX_W-1:0]     grant_idx, grant_idx_nxt;
    logic [IDX_W-1:0]     last_grant, last_grant_nxt;

    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_found;

    logic [63:0]          hdr_sel;
    logic [63:0]          data_sel;
    logic [7:0]           keep_sel;
    logic                 last_sel;
    logic                 hdr_valid_sel;
    logic                 data_valid_sel;

    // Scan upward from the port after the last owner so every requester gets a turn.
    always_comb begin : rr_pick
        cand       = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = IDX_W'((int'(last_grant) + 1 + i) % NUM_PORTS);
            if (!pick_found && s_udphdr_tvalid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin : port_mux
        hdr_sel  = '0;
        data_sel = '0;
        keep_sel = '0;
        last_sel = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_idx == IDX_W'(p)) begin
                hdr_sel  = s_udphdr_tdata[64*p +: 64];
                data_sel = s_udpdata_tdata[64*p +: 64];
                keep_sel = s_udpdata_tkeep[8*p +: 8];
                last_sel = s_udpdata_tlast[p];
            end
        end
    end

    assign hdr_valid_sel  = |(s_udphdr_tvalid & grant);
    assign data_valid_sel = |(s_udpdata_tvalid & grant);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            grant      <= '0;
            grant_idx  <= '0;
            last_grant <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            grant_idx  <= grant_idx_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin : fsm_comb
        state_nxt        = state;
        grant_nxt        = grant;
        grant_idx_nxt    = grant_idx;
        last_grant_nxt   = last_grant;
        s_udphdr_tready  = '0;
        s_udpdata_tready = '0;
        m_udphdr_tdata   = '0;
        m_udphdr_tvalid  = 1'b0;
        m_udpdata_tdata  = '0;
        m_udpdata_tkeep  = '0;
        m_udpdata_tlast  = 1'b0;
        m_udpdata_tvalid = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_nxt           = '0;
                    grant_nxt[pick_idx] = 1'b1;
                    grant_idx_nxt       = pick_idx;
                    state_nxt           = ST_HEADER;
                end
            end
            ST_HEADER: begin
                // A granted port that withdraws its header simply stalls here.
                m_udphdr_tdata  = hdr_sel;
                m_udphdr_tvalid = hdr_valid_sel;
                s_udphdr_tready = grant & {NUM_PORTS{m_udphdr_tready}};
                if (hdr_valid_sel && m_udphdr_tready) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                m_udpdata_tdata  = data_sel;
                m_udpdata_tkeep  = keep_sel;
                m_udpdata_tlast  = last_sel;
                m_udpdata_tvalid = data_valid_sel;
                s_udpdata_tready = grant & {NUM_PORTS{m_udpdata_tready}};
                if (data_valid_sel && m_udpdata_tready && last_sel) begin
                    last_grant_nxt = grant_idx;
                    grant_nxt      = '0;
                    state_nxt      = ST_IDLE;
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign grant_o   = grant;
    assign busy_o    = (state != ST_IDLE);
    assign dbg_state = (DEBUG == "TRUE") ? state : 2'b00;

endmodule
